sram_ctrl: RTL and testbench

Clocked initiator that drives the team's asynchronous SRAM (active-low write enable, address-driven read, combinational read data) from a synchronous valid/ready request port. It sits between the CPU load/store stage and the SRAM macro. It sequences address setup, the write-enable pulse and hold, and read wait states so the SRAM pins never change while write-enable is asserted. It returns one response per accepted request.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the synchronous-to-async SRAM initiator.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSETUP,
    WPULSE,
    WHOLD
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Valid/ready front end that sequences address setup, write-enable pulse/hold
// and read wait states for an asynchronous SRAM with combinational read data.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int CNT_W = $clog2(max_int(RD_WAIT, WR_WAIT)) + 1;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_WAIT - 1);

  if (RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_wait
    $error("sram_ctrl: RD_WAIT and WR_WAIT must both be >= 1");
  end

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             we_n_nxt;
  logic             resp_valid_nxt;
  logic             rdata_ld;
  logic             accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    we_n_nxt       = 1'b1;
    resp_valid_nxt = 1'b0;
    rdata_ld       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_we) begin
            state_nxt = WSETUP;
          end else begin
            state_nxt = RD;
            cnt_nxt   = RD_INIT;
          end
        end
      end
      RD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          rdata_ld       = 1'b1;
          resp_valid_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      // Address/data have been stable for a full cycle before we_n drops.
      WSETUP: begin
        state_nxt = WPULSE;
        cnt_nxt   = WR_INIT;
        we_n_nxt  = 1'b0;
      end
      WPULSE: begin
        if (cnt != '0) begin
          cnt_nxt  = cnt - CNT_W'(1);
          we_n_nxt = 1'b0;
        end else begin
          state_nxt = WHOLD;
        end
      end
      WHOLD: begin
        resp_valid_nxt = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pins only move on an accept edge, which can only occur in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
      sram_din   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      sram_we_n  <= we_n_nxt;
      resp_valid <= resp_valid_nxt;
      if (accept) begin
        sram_addr <= req_addr;
        if (req_we) sram_din <= req_wdata;
      end
      if (rdata_ld) resp_rdata <= sram_dout;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench: two controllers (RD/WR wait 2/2 and 1/3) against async SRAM models,
// checked every cycle by a transaction-timing reference model.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        sram_we_n  [2];
  logic [15:0] sram_addr  [2];
  logic [15:0] sram_din   [2];
  logic [15:0] sram_dout  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int rdw(input int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int wrw(input int k); return (k == 0) ? 2 : 3; endfunction
  function automatic logic [15:0] pat(input int a); return 16'(a) ^ 16'h5A5A; endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] smem [65536];

    sram_ctrl #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16),
      .RD_WAIT((g == 0) ? 2 : 1), .WR_WAIT((g == 0) ? 2 : 3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
      .sram_we_n(sram_we_n[g]), .sram_addr(sram_addr[g]), .sram_din(sram_din[g]),
      .sram_dout(sram_dout[g])
    );

    // Async SRAM: combinational read, stores while we_n is low.
    initial for (int i = 0; i < 65536; i++) smem[i] = pat(i);
    assign sram_dout[g] = smem[sram_addr[g]];
    always @(posedge clk) if (sram_we_n[g] === 1'b0) smem[sram_addr[g]] = sram_din[g];
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: phase = cycles since the accept edge, -1 when idle.
  int          m_ph  [2] = '{-1, -1};
  int          m_len [2] = '{1, 1};
  bit          m_we  [2];
  logic [15:0] m_addr[2];
  logic [15:0] m_din [2];
  logic [15:0] m_rd  [2];
  logic [15:0] mmem  [2][65536];
  bit          mval  [2][65536];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit busy;
      if (rst) begin
        m_ph[k] = -1; m_addr[k] = '0; m_din[k] = '0; m_rd[k] = '0;
      end
      busy = (m_ph[k] >= 0) && (m_ph[k] < m_len[k]);
      chk("req_ready", k, req_ready[k], !busy);
      chk("sram_we_n", k, sram_we_n[k],
          !(m_we[k] && busy && m_ph[k] >= 1 && m_ph[k] <= wrw(k)));
      chk("sram_addr", k, sram_addr[k], m_addr[k]);
      chk("sram_din", k, sram_din[k], m_din[k]);
      chk("resp_valid", k, resp_valid[k], m_ph[k] == m_len[k]);
      chk("resp_rdata", k, resp_rdata[k], m_rd[k]);
      if (!rst) begin
        if (!busy && req_valid[k]) begin
          m_ph[k]   = 0;
          m_we[k]   = req_we[k];
          m_addr[k] = req_addr[k];
          if (req_we[k]) m_din[k] = req_wdata[k];
          m_len[k]  = req_we[k] ? wrw(k) + 2 : rdw(k);
        end else if (busy) begin
          m_ph[k]++;
          if (m_ph[k] == m_len[k]) begin
            if (m_we[k]) begin
              mmem[k][m_addr[k]] = m_din[k];
              mval[k][m_addr[k]] = 1'b1;
            end else begin
              m_rd[k] = mval[k][m_addr[k]] ? mmem[k][m_addr[k]] : pat(m_addr[k]);
            end
          end
        end else begin
          m_ph[k] = -1;
        end
      end
    end
  end

  // Waits (bounded) until ready is seen; the following posedge is the accept edge.
  task automatic wait_ready(input int k);
    int n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", k, req_ready[k], 1);
  endtask

  // Called just after an accept edge: phase of response, data, cycles of we_n low.
  task automatic wait_resp(input int k, output int lat, output logic [15:0] rd, output int wl);
    lat = 0; wl = 0; rd = 'x;
    forever begin
      @(negedge clk);
      if (!sram_we_n[k]) wl++;
      if (resp_valid[k]) begin rd = resp_rdata[k]; break; end
      if (lat >= 50) break;
      lat++;
    end
  endtask

  task automatic do_req(input int k, input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output int wl);
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d;
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    wait_resp(k, lat, rd, wl);
  endtask

  initial begin
    int lat, wl, n;
    logic [15:0] rd;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wl, n;
    logic [15:0] rd;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_we_n", k, sram_we_n[k], 1);
      chk("rst_addr", k, sram_addr[k], 16'h0000);
      chk("rst_resp_valid", k, resp_valid[k], 0);
      chk("rst_ready", k, req_ready[k], 1);
    end

    // Write then read on the 2/2 controller.
    do_req(0, 1, 16'h0012, 16'hBEEF, lat, rd, wl);
    chk("wr_lat", 0, lat, 4);
    chk("wr_we_low", 0, wl, 2);
    do_req(0, 0, 16'h0012, 16'h0000, lat, rd, wl);
    chk("rd_lat", 0, lat, 2);
    chk("rd_data", 0, rd, 16'hBEEF);

    // Back-to-back reads with req_valid held.
    do_req(0, 1, 16'h0001, 16'h1111, lat, rd, wl);
    do_req(0, 1, 16'h0002, 16'h2222, lat, rd, wl);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0001;
    wait_ready(0);
    @(posedge clk); #1;
    req_addr[0] = 16'h0002;
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    chk("b2b_gap", 0, n, 2);
    chk("b2b_resp1_valid", 0, resp_valid[0], 1);
    chk("b2b_resp1_data", 0, resp_rdata[0], 16'h1111);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, lat, rd, wl);
    chk("b2b_resp2_lat", 0, lat, 2);
    chk("b2b_resp2_data", 0, rd, 16'h2222);

    // 1/3 controller.
    do_req(1, 0, 16'h0012, 16'h0000, lat, rd, wl);
    chk("rd_lat", 1, lat, 1);
    chk("rd_data", 1, rd, 16'h5A48);
    do_req(1, 1, 16'h0030, 16'h1234, lat, rd, wl);
    chk("wr_lat", 1, lat, 5);
    chk("wr_we_low", 1, wl, 3);
    do_req(1, 0, 16'h0030, 16'h0000, lat, rd, wl);
    chk("rd_back", 1, rd, 16'h1234);

    // Top of the address space; location 0 keeps its preload.
    do_req(0, 1, 16'hFFFF, 16'hA5A5, lat, rd, wl);
    do_req(0, 0, 16'hFFFF, 16'h0000, lat, rd, wl);
    chk("wrap_rd", 0, rd, 16'hA5A5);
    do_req(0, 0, 16'h0000, 16'h0000, lat, rd, wl);
    chk("zero_rd", 0, rd, 16'h5A5A);

    // Reset in the middle of the write pulse.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h4000; req_wdata[0] = 16'hDEAD;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (sram_we_n[0] && n < 20) begin @(negedge clk); n++; end
    chk("pulse_seen", 0, sram_we_n[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_async_we_n", 0, sram_we_n[0], 1);
    chk("rst_async_resp", 0, resp_valid[0], 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clk); if (resp_valid[0]) n++; end
    chk("dropped_no_resp", 0, n, 0);

    // Random traffic; req_valid and payload change freely while busy.
    repeat (3000) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        int a;
        a = $urandom_range(0, 17);
        req_valid[k] = ($urandom_range(0, 2) != 0);
        req_we[k]    = $urandom_range(0, 1) != 0;
        req_addr[k]  = (a < 16) ? 16'(a) : 16'(16'hFFFF - (a - 16));
        req_wdata[k] = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
